// File: rtl/ser_stream_pkg.sv
// ser_stream_pkg: shared state and word types for the ser_stream serializer.
// Word fields are sized for the widest supported DATA_W; narrower instances use the low bits.
package ser_stream_pkg;
  localparam int MAX_W = 64;
  localparam int LEN_W = $clog2(MAX_W) + 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic [LEN_W-1:0] len;
    logic             lsb_first;
  } word_t;
endpackage

// File: rtl/ser_stream_shifter.sv
// ser_stream_shifter: shift register, length counter and bit select for one word.
module ser_stream_shifter
  import ser_stream_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic  clk_i,
  input  logic  arstn_i,
  input  logic  load_i,
  input  word_t word_i,
  input  logic  adv_i,
  output logic  bit_o,
  output logic  last_o
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  logic [DATA_W-1:0] sr_q, sr_d, ld_data;
  logic [CNT_W-1:0]  cnt_q, cnt_d, ld_len;
  logic              lsb_q, lsb_d, adv, unused_hi;
  assign ld_len = word_i.len[CNT_W-1:0];
  // MSB-first words are left-aligned so bit L-1 sits at the top and upper bits fall off.
  assign ld_data = word_i.lsb_first ? word_i.data[DATA_W-1:0]
                                    : word_i.data[DATA_W-1:0] << (CNT_W'(DATA_W) - ld_len);
  assign unused_hi = ^{word_i.data >> DATA_W, word_i.len >> CNT_W};
  assign adv = adv_i && cnt_q != '0;
  assign sr_d = load_i ? ld_data : adv ? (lsb_q ? sr_q >> 1 : sr_q << 1) : sr_q;
  assign cnt_d = load_i ? ld_len : adv ? cnt_q - 1'b1 : cnt_q;
  assign lsb_d = load_i ? word_i.lsb_first : lsb_q;
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
      lsb_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      lsb_q <= lsb_d;
    end
  assign bit_o  = cnt_q != '0 && (lsb_q ? sr_q[0] : sr_q[DATA_W-1]);
  assign last_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/ser_stream.sv
// ser_stream: variable-length word serializer with a one-word pending buffer.
// Owns the word handshake, pending register and IDLE/SHIFT state; the shifter does the bits.
module ser_stream
  import ser_stream_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MIN_LEN = 3,
  localparam int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_lsb_first_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  input  logic              ser_ready_i,
  output logic              busy_o
);
  localparam int CNT_W = MOD_W + 1;
  state_t           state_q;
  word_t            pend_q, in_w, ld_w;
  logic             pend_v_q, take, beat, last_beat, load;
  logic [CNT_W-1:0] len;
  assign len = data_mod_i == '0 ? CNT_W'(DATA_W) : {1'b0, data_mod_i};
  assign data_ready_o = !pend_v_q;
  // Short words still complete the handshake but never reach the shifter.
  assign take = data_val_i && data_ready_o && len >= CNT_W'(MIN_LEN);
  assign in_w = '{data: MAX_W'(data_i), len: LEN_W'(len), lsb_first: data_lsb_first_i};
  assign ser_data_val_o = state_q == SHIFT;
  assign beat = ser_data_val_o && ser_ready_i;
  assign last_beat = beat && ser_last_o;
  assign load = (state_q == IDLE && take) || (last_beat && (pend_v_q || take));
  assign ld_w = pend_v_q ? pend_q : in_w;
  assign busy_o = ser_data_val_o || pend_v_q;
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      state_q  <= IDLE;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      state_q <= load ? SHIFT : last_beat ? IDLE : state_q;
      if (last_beat && pend_v_q)
        pend_v_q <= 1'b0;
      else if (take && state_q == SHIFT && !last_beat) begin
        pend_v_q <= 1'b1;
        pend_q   <= in_w;
      end
    end
  ser_stream_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .load_i (load),
    .word_i (ld_w),
    .adv_i  (beat),
    .bit_o  (ser_data_o),
    .last_o (ser_last_o)
  );
endmodule

// File: tb/tb_ser_stream.sv
// tb_ser_stream: directed stimulus with a bit scoreboard for ser_stream (DATA_W=16).
module tb_ser_stream;
  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic [15:0] data_i;
  logic [3:0]  data_mod_i;
  logic        data_lsb_first_i, data_val_i, data_ready_o;
  logic        ser_data_o, ser_data_val_o, ser_last_o, ser_ready_i, busy_o;
  int          chk_cnt = 0, pass_cnt = 0, cyc = 0, acc_cyc = 0, last_cyc = -1;
  logic [1:0]  exp_q[$];

  ser_stream #(.DATA_W(16), .MIN_LEN(3)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .data_i(data_i), .data_mod_i(data_mod_i),
    .data_lsb_first_i(data_lsb_first_i), .data_val_i(data_val_i), .data_ready_o(data_ready_o),
    .ser_data_o(ser_data_o), .ser_data_val_o(ser_data_val_o), .ser_last_o(ser_last_o),
    .ser_ready_i(ser_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [3:0] m, input logic lsb);
    int l;
    l = (m == 0) ? 16 : int'(m);
    if (l < 3) return;
    for (int i = 0; i < l; i++) begin
      int idx;
      idx = lsb ? i : l - 1 - i;
      exp_q.push_back({d[idx], i == l - 1});
    end
  endtask

  // Offers a word, waits (bounded) for acceptance, returns in the cycle after acceptance.
  task automatic offer(input logic [15:0] d, input logic [3:0] m, input logic lsb);
    int n;
    data_i = d; data_mod_i = m; data_lsb_first_i = lsb; data_val_i = 1'b1;
    n = 0;
    while (!data_ready_o && n < 50) begin step(); n++; end
    if (!data_ready_o) check("offer_timeout", 32'(data_ready_o), 1);
    step();
    acc_cyc = cyc - 1;
    data_val_i = 1'b0;
    push_exp(d, m, lsb);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 200) begin step(); n++; end
    check(name, 32'(busy_o || exp_q.size() != 0), 0);
  endtask

  always @(negedge clk_i)
    if (arstn_i && ser_data_val_o && ser_ready_i) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_bit: got bit %0b last %0b with nothing expected", ser_data_o, ser_last_o);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("bit_last", {30'd0, ser_data_o, ser_last_o}, {30'd0, e});
        if (ser_last_o) last_cyc = cyc;
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low, seen, a;
    arstn_i = 1'b0; ser_ready_i = 1'b1; data_val_i = 1'b0;
    data_i = '0; data_mod_i = '0; data_lsb_first_i = 1'b0;
    #2;
    check("rst_ready", 32'(data_ready_o), 1);
    check("rst_outs", {28'd0, ser_data_o, ser_data_val_o, ser_last_o, busy_o}, 0);
    step(); step();
    arstn_i = 1'b1;
    step();
    // Full 16-bit word, MSB-first
    offer(16'hA5C3, 4'd0, 1'b0);
    check("t1_first_valid", 32'(ser_data_val_o), 1);
    low = 0;
    for (int i = 0; i < 17; i++) begin low += int'(!data_ready_o); step(); end
    drain("t1_drain");
    check("t1_ready_held", 32'(low), 0);
    check("t1_last_time", 32'(last_cyc - acc_cyc), 16);
    // 5-bit LSB-first, upper bits ignored
    offer(16'hFF13, 4'd5, 1'b1);
    drain("t2_drain");
    check("t2_last_time", 32'(last_cyc - acc_cyc), 5);
    // Short word dropped
    offer(16'hFFFF, 4'd2, 1'b0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin seen += int'(busy_o || ser_data_val_o); step(); end
    check("t3_no_activity", 32'(seen), 0);
    check("t3_ready", 32'(data_ready_o), 1);
    // Back-to-back words through the pending buffer
    offer(16'h0009, 4'd4, 1'b0);
    a = acc_cyc;
    offer(16'h0003, 4'd3, 1'b0);
    check("t4_ready_drop", 32'(data_ready_o), 0);
    low = 0;
    while (!data_ready_o && low < 10) begin low++; step(); end
    check("t4_ready_low_cycles", 32'(low), 3);
    drain("t4_drain");
    check("t4_last_time", 32'(last_cyc - a), 7);
    // Backpressure on bit 2 of an 8-bit word
    offer(16'h00B4, 4'd8, 1'b0);
    step(); step();
    ser_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_hold", {29'd0, ser_data_val_o, ser_data_o, ser_last_o}, 3'b110);
      step();
    end
    ser_ready_i = 1'b1;
    drain("t5_drain");
    check("t5_last_time", 32'(last_cyc - acc_cyc), 11);
    // Asynchronous reset mid-word, then a clean restart
    offer(16'hA5C3, 4'd0, 1'b0);
    repeat (4) step();
    check("t6_active_before_rst", 32'(ser_data_val_o), 1);
    arstn_i = 1'b0;
    #1;
    check("t6_rst_outs", {28'd0, ser_data_o, ser_data_val_o, ser_last_o, busy_o}, 0);
    check("t6_rst_ready", 32'(data_ready_o), 1);
    exp_q.delete();
    step();
    arstn_i = 1'b1;
    step();
    offer(16'h0006, 4'd4, 1'b1);
    drain("t6_drain");
    check("t6_last_time", 32'(last_cyc - acc_cyc), 4);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
